// File: rtl/sram_rw.sv
// Single-port synchronous SRAM with a request/valid protocol, optional
// zero-fill after reset, and range checking against LENGTH.
module sram_rw #(
    parameter int ADDR           = 4,
    parameter int WIDTH          = 8,
    parameter int LENGTH         = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             we,
    input  logic [ADDR-1:0]  address,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             ready,
    output logic             err,
    output logic             state_dbg
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR-1:0] LAST_WORD = ADDR'(LENGTH - 1);

    state_t            state_q, state_d;
    logic [ADDR-1:0]   clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]  mem [LENGTH];
    logic              accept;
    logic              in_range;

    // Handshake: a request is taken on any rising edge where cs and ready are
    // both high; there is no other back-pressure. valid/err pulse for exactly
    // the cycle after the request that produced them.
    assign ready     = (state_q == READY) && !rst;
    assign accept    = cs && ready;
    assign in_range  = int'(address) < LENGTH;
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_WORD) begin
                    state_d   = READY;
                    clr_cnt_d = '0;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // The array itself is never reset, so contents survive rst when no clear follows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (accept && we && in_range) begin
                mem[address] <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (accept) begin
                if (!in_range) begin
                    err <= 1'b1;
                    if (!we) begin
                        data_out <= '0;
                        valid    <= 1'b1;
                    end
                end else if (!we) begin
                    data_out <= mem[address];
                    valid    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_rw.sv
// Directed bench for sram_rw: three instances (default, LENGTH=12, and
// CLEAR_ON_RESET=0) driven from a shared bus with per-instance cs and rst.
module tb_sram_rw;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] cs;
    logic       we;
    logic [3:0] address;
    logic [7:0] data_in;
    logic [7:0] dout [3];
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] err;
    logic [2:0] dbg;

    int n_checks;
    int n_fail;

    sram_rw #(.ADDR(4), .WIDTH(8), .LENGTH(16), .CLEAR_ON_RESET(1)) u_def (
        .clk(clk), .rst(rst[0]), .cs(cs[0]), .we(we), .address(address),
        .data_in(data_in), .data_out(dout[0]), .valid(valid[0]),
        .ready(ready[0]), .err(err[0]), .state_dbg(dbg[0])
    );

    sram_rw #(.ADDR(4), .WIDTH(8), .LENGTH(12), .CLEAR_ON_RESET(1)) u_len12 (
        .clk(clk), .rst(rst[1]), .cs(cs[1]), .we(we), .address(address),
        .data_in(data_in), .data_out(dout[1]), .valid(valid[1]),
        .ready(ready[1]), .err(err[1]), .state_dbg(dbg[1])
    );

    sram_rw #(.ADDR(4), .WIDTH(8), .LENGTH(16), .CLEAR_ON_RESET(0)) u_keep (
        .clk(clk), .rst(rst[2]), .cs(cs[2]), .we(we), .address(address),
        .data_in(data_in), .data_out(dout[2]), .valid(valid[2]),
        .ready(ready[2]), .err(err[2]), .state_dbg(dbg[2])
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change and outputs are sampled 1ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic w, input logic [3:0] a, input logic [7:0] di);
        cs      = 3'b000;
        cs[d]   = 1'b1;
        we      = w;
        address = a;
        data_in = di;
    endtask

    task automatic idle();
        cs      = 3'b000;
        we      = 1'b0;
        address = 4'd0;
        data_in = 8'd0;
    endtask

    task automatic test_reset();
        int low0, low1;
        rst = 3'b111;
        idle();
        cycle();
        cycle();
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (dout[d] !== 8'h00 || valid[d] !== 1'b0 || err[d] !== 1'b0 || ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: dout=%h valid=%b err=%b ready=%b, want 00 0 0 0",
                         d, dout[d], valid[d], err[d], ready[d]);
            end
        end
        rst = 3'b000;
        #1;
        n_checks++;
        if (ready[2] !== 1'b1 || dbg[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL noclear_ready_after_reset: ready=%b state=%b, want 1 1", ready[2], dbg[2]);
        end
        n_checks++;
        if (dbg[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_state_after_reset: state=%b, want 0", dbg[0]);
        end
        low0 = 0;
        low1 = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ready[0]) low0++;
            if (!ready[1]) low1++;
            cycle();
        end
        n_checks++;
        if (low0 !== 16 || ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_length_16: low cycles=%0d ready=%b, want 16 1", low0, ready[0]);
        end
        n_checks++;
        if (low1 !== 12 || ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_length_12: low cycles=%0d ready=%b, want 12 1", low1, ready[1]);
        end
    endtask

    task automatic test_clear_reads();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b0, 4'(i), 8'h00);
            cycle();
            n_checks++;
            if (dout[0] !== 8'h00 || valid[0] !== 1'b1 || err[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL cleared_read addr %0d: dout=%h valid=%b err=%b, want 00 1 0",
                         i, dout[0], valid[0], err[0]);
            end
        end
        idle();
        cycle();
        n_checks++;
        if (valid[0] !== 1'b0 || err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drops_after_reads: valid=%b err=%b, want 0 0", valid[0], err[0]);
        end
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 4'd3, 8'hA5);
        cycle();
        n_checks++;
        if (valid[0] !== 1'b0 || err[0] !== 1'b0 || dout[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL write_no_response: dout=%h valid=%b err=%b, want 00 0 0",
                     dout[0], valid[0], err[0]);
        end
        drive(0, 1'b0, 4'd3, 8'h00);
        cycle();
        n_checks++;
        if (dout[0] !== 8'hA5 || valid[0] !== 1'b1 || err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after_write: dout=%h valid=%b err=%b, want a5 1 0",
                     dout[0], valid[0], err[0]);
        end
        idle();
        cycle();
        n_checks++;
        if (dout[0] !== 8'hA5 || valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL data_out_hold: dout=%h valid=%b, want a5 0", dout[0], valid[0]);
        end
    endtask

    task automatic test_out_of_range();
        drive(1, 1'b1, 4'd5, 8'h77);
        cycle();
        drive(1, 1'b0, 4'd5, 8'h00);
        cycle();
        n_checks++;
        if (dout[1] !== 8'h77 || valid[1] !== 1'b1 || err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL len12_read5: dout=%h valid=%b err=%b, want 77 1 0", dout[1], valid[1], err[1]);
        end
        drive(1, 1'b0, 4'd13, 8'h00);
        cycle();
        n_checks++;
        if (dout[1] !== 8'h00 || valid[1] !== 1'b1 || err[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_read13: dout=%h valid=%b err=%b, want 00 1 1", dout[1], valid[1], err[1]);
        end
        idle();
        cycle();
        n_checks++;
        if (valid[1] !== 1'b0 || err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_pulse_width: valid=%b err=%b, want 0 0", valid[1], err[1]);
        end
        drive(1, 1'b1, 4'd14, 8'h99);
        cycle();
        n_checks++;
        if (valid[1] !== 1'b0 || err[1] !== 1'b1 || dout[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL oor_write14: dout=%h valid=%b err=%b, want 00 0 1", dout[1], valid[1], err[1]);
        end
        drive(1, 1'b0, 4'd12, 8'h00);
        cycle();
        n_checks++;
        if (err[1] !== 1'b1 || valid[1] !== 1'b1 || dout[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL oor_boundary12: dout=%h valid=%b err=%b, want 00 1 1", dout[1], valid[1], err[1]);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1, 1'b0, 4'(i), 8'h00);
            cycle();
            n_checks++;
            if (dout[1] !== ((i == 5) ? 8'h77 : 8'h00) || valid[1] !== 1'b1 || err[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL len12_unchanged addr %0d: dout=%h valid=%b err=%b, want %h 1 0",
                         i, dout[1], valid[1], err[1], (i == 5) ? 8'h77 : 8'h00);
            end
        end
        idle();
        cycle();
    endtask

    task automatic test_cs_during_clear();
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            drive(0, (i < 3), 4'd2, 8'hFF);
            cycle();
            n_checks++;
            if (valid[0] !== 1'b0 || err[0] !== 1'b0 || ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL ignored_while_clearing step %0d: valid=%b err=%b ready=%b, want 0 0 0",
                         i, valid[0], err[0], ready[0]);
            end
        end
        idle();
        cycle();
        n_checks++;
        if (ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_clear: ready=%b, want 1", ready[0]);
        end
        drive(0, 1'b0, 4'd2, 8'h00);
        cycle();
        n_checks++;
        if (dout[0] !== 8'h00 || valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL blocked_write_addr2: dout=%h valid=%b, want 00 1", dout[0], valid[0]);
        end
        drive(0, 1'b0, 4'd3, 8'h00);
        cycle();
        n_checks++;
        if (dout[0] !== 8'h00 || valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reclear_addr3: dout=%h valid=%b, want 00 1", dout[0], valid[0]);
        end
        idle();
        cycle();
    endtask

    task automatic test_reset_mid_clear();
        int low0;
        drive(0, 1'b1, 4'd0, 8'h5A);
        cycle();
        drive(0, 1'b1, 4'd15, 8'hC3);
        cycle();
        idle();
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        low0 = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ready[0]) low0++;
            cycle();
        end
        n_checks++;
        if (low0 !== 16 || ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear_length: low cycles=%0d ready=%b, want 16 1", low0, ready[0]);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b0, 4'(i), 8'h00);
            cycle();
            n_checks++;
            if (dout[0] !== 8'h00 || valid[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL restart_clear_read addr %0d: dout=%h valid=%b, want 00 1", i, dout[0], valid[0]);
            end
        end
        idle();
        cycle();
    endtask

    task automatic test_no_clear();
        drive(2, 1'b1, 4'd9, 8'h3C);
        cycle();
        drive(2, 1'b1, 4'd9, 8'h11);
        rst[2] = 1'b1;
        cycle();
        idle();
        rst[2] = 1'b0;
        #1;
        n_checks++;
        if (ready[2] !== 1'b1 || valid[2] !== 1'b0 || err[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL keep_ready_after_pulse: ready=%b valid=%b err=%b, want 1 0 0",
                     ready[2], valid[2], err[2]);
        end
        drive(2, 1'b0, 4'd9, 8'h00);
        cycle();
        n_checks++;
        if (dout[2] !== 8'h3C || valid[2] !== 1'b1 || err[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL keep_contents_addr9: dout=%h valid=%b err=%b, want 3c 1 0",
                     dout[2], valid[2], err[2]);
        end
        idle();
        cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clear_reads();
        test_write_read();
        test_out_of_range();
        test_cs_during_clear();
        test_reset_mid_clear();
        test_no_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_rw.md
SRAM_RW -- requirements
Module: sram_rw

Interface
REQ-001 The block SHALL have parameter ADDR, default 4, address width in bits.
REQ-002 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-003 The block SHALL have parameter LENGTH, default 16, number of words; legal range 2 <= LENGTH <= 2**ADDR.
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1; 1 means zero-fill the array after reset, 0 means retain contents.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-007 The block SHALL have port cs, input, 1 bit, request strobe (chip select).
REQ-008 The block SHALL have port we, input, 1 bit, 1 = write request, 0 = read request; qualified by cs.
REQ-009 The block SHALL have port address, input, ADDR bits, word address.
REQ-010 The block SHALL have port data_in, input, WIDTH bits, write data.
REQ-011 The block SHALL have port data_out, output, WIDTH bits, registered read data.
REQ-012 The block SHALL have port valid, output, 1 bit, one-cycle pulse marking new data_out.
REQ-013 The block SHALL have port ready, output, 1 bit, high when requests are accepted.
REQ-014 The block SHALL have port err, output, 1 bit, one-cycle pulse for an out-of-range request.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 The block SHALL drive ready = (state == READY) and not rst, combinationally.
REQ-017 The block SHALL, in CLEAR, write 0 to word clr_cnt each cycle, clr_cnt counting 0..LENGTH-1, then enter READY on the edge that writes word LENGTH-1 (CLEAR lasts exactly LENGTH cycles).
REQ-018 The block SHALL ignore cs, we, address and data_in while ready is low: no write, no valid, no err.
REQ-019 The block SHALL accept a request on an edge where cs and ready are both high; one request per cycle, no back-pressure beyond ready.
REQ-020 The block SHALL, on an accepted write with address < LENGTH, store data_in at mem[address]; data_out, valid and err remain unchanged/low.
REQ-021 The block SHALL, on an accepted read with address < LENGTH, load mem[address] into data_out at that edge and assert valid for exactly the following cycle (latency 1).
REQ-022 The block SHALL return the most recently written value on a read issued the cycle after a write to the same address.
REQ-023 The block SHALL, on an accepted request with address >= LENGTH, leave the array unmodified and pulse err for one cycle; for a read it also loads data_out with 0 and pulses valid.
REQ-024 The block SHALL hold data_out between reads; valid and err SHALL be low in every cycle not following an accepted read or out-of-range request.
REQ-025 The block SHALL support back-to-back reads, producing a valid pulse in each consecutive cycle.

Reset
REQ-026 The block SHALL, on any edge with rst high, set data_out=0, valid=0, err=0, clr_cnt=0, with state=CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-027 The block SHALL restart the clear from word 0 when rst is asserted mid-CLEAR, and SHALL abandon any request coincident with rst.
REQ-028 The block SHALL NOT modify array contents during reset; with CLEAR_ON_RESET=0, contents survive reset.

Verification
REQ-029 The bench SHALL cover this case: defaults, rst 1 cycle -> ready low 16 cycles, then high; reads of addresses 0..15 all return 0 with valid each cycle.
REQ-030 The bench SHALL cover this case: write 0xA5 to addr 3, next cycle read addr 3 -> data_out=0xA5, valid=1 one cycle later, err=0.
REQ-031 The bench SHALL cover this case: LENGTH=12, read addr 13 -> data_out=0, valid=1, err=1 for one cycle; write addr 14 -> err=1, valid=0, array unchanged.
REQ-032 The bench SHALL cover this case: rst re-asserted at clear cycle 7 -> ready stays low a full further 16 cycles after release; every word reads 0.
REQ-033 The bench SHALL cover this case: CLEAR_ON_RESET=0, write 0x3C to addr 9, pulse rst -> ready high the cycle after release, read addr 9 returns 0x3C.
REQ-034 The bench SHALL cover this case: cs=1 with ready=0 (during CLEAR), write 0xFF to addr 2 -> no effect; after clear, read addr 2 returns 0.
